// File: rtl/tdc_link_pkg.sv
// Shared constants and types for the TDC serial link (transmitter and receiver).
package tdc_link_pkg;
    localparam int TDC_WORD_W          = 48;
    localparam int TDC_WORD_BYTES      = 6;
    localparam int UART_DATA_BITS      = 8;
    localparam int DEFAULT_CLK_PER_BIT = 17;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;
endpackage

// File: rtl/serial_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser on rx, then a mid-bit sampling byte FSM.
module serial_rx_byte
    import tdc_link_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      byte_valid,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      frame_err,
    output logic                      idle
);
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    rx_state_t                 state, state_d;
    logic                      rx_meta, rx_sync;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [BIT_W-1:0]          bit_idx, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift, shift_d;
    logic                      byte_valid_d, frame_err_d;

    // NOTE: sequential state uses <= so every flop samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            shift      <= shift_d;
            byte_valid <= byte_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_idx_d    = bit_idx;
        shift_d      = shift;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync, shift[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx + BIT_W'(1);
                    if (bit_idx == LAST_BIT) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        byte_valid_d = 1'b1;
                        state_d      = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data = shift;
    assign idle      = (state == RX_IDLE);
endmodule

// File: rtl/tdc_serial_rx_manager.sv
// TDC serial link receiver: assembles 6 UART bytes (MSB first) into 48-bit words and queues them in a FIFO.
module tdc_serial_rx_manager
    import tdc_link_pkg::*;
#(
    parameter int CLK_PER_BIT  = DEFAULT_CLK_PER_BIT,
    parameter int DEPTH        = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic                    rd_en,
    output logic [TDC_WORD_W-1:0]   dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    frame_err,
    output logic                    sync_err,
    output logic                    overflow
);
    localparam int AW       = $clog2(DEPTH);
    localparam int IDX_W    = $clog2(TDC_WORD_BYTES);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLK_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT);
    localparam int SH_W     = TDC_WORD_W - UART_DATA_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TDC_WORD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

    logic                      byte_valid, rx_idle;
    logic [UART_DATA_BITS-1:0] byte_data;
    logic [IDX_W-1:0]          byte_idx;
    logic [SH_W-1:0]           word_sh;
    logic [TO_W-1:0]           to_cnt;
    logic                      push, push_ok, pop;
    logic [TDC_WORD_W-1:0]     push_word;
    logic [TDC_WORD_W-1:0]     mem [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               count_q;

    serial_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx_byte (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .idle       (rx_idle)
    );

    // Earlier bytes shift up, so after six bytes the first one sits in the top byte lane.
    assign push      = byte_valid && (byte_idx == LAST_IDX);
    assign push_word = {word_sh, byte_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= '0;
            word_sh  <= '0;
            to_cnt   <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (frame_err) begin
                byte_idx <= '0;
                to_cnt   <= '0;
            end else if (byte_valid) begin
                word_sh  <= {word_sh[SH_W-UART_DATA_BITS-1:0], byte_data};
                byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);
                to_cnt   <= '0;
            end else if (byte_idx != '0 && rx_idle) begin
                if (to_cnt == TO_LAST) begin
                    sync_err <= 1'b1;
                    byte_idx <= '0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop     = rd_en && !empty;
    assign count   = count_q;

    // NOTE: the storage array has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && full) overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
